iiitb_fifo_param: RTL and testbench
===================================

// Module: iiitb_fifo_param
// PURPOSE
//   Parametrised synchronous FIFO; next generation of the 16x8 status-flag FIFO.
//   Configurable width/depth, registered read port with valid strobe, occupancy count,
//   programmable almost-full/almost-empty levels, sticky error flags with explicit clear.
//   Single clock domain; sits between producer/consumer blocks of the datapath.
// PARAMETERS
//   DATA_W    8    data word width, bits (>=1)
//   DEPTH     16   number of entries; power of two, >=4
//   AF_LEVEL  12   almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  4    almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//   Local: AW = $clog2(DEPTH); pointers AW+1 bits (MSB = wrap bit)
// PORTS
//   clk           in   1        clock, rising edge
//   rst           in   1        synchronous reset, active-high
//   wr            in   1        write request
//   data_in       in   DATA_W   write data
//   rd            in   1        read request
//   data_out      out  DATA_W   read data, registered
//   rd_valid      out  1        data_out holds new word this cycle
//   clr_flags     in   1        clear sticky overflow/underflow (and peak)
//   fifo_full     out  1        count == DEPTH
//   fifo_empty    out  1        count == 0
//   almost_full   out  1        count >= AF_LEVEL
//   almost_empty  out  1        count <= AE_LEVEL
//   fifo_overflow out  1        sticky: write rejected
//   fifo_underflow out 1        sticky: read rejected
//   count         out  AW+1     current occupancy 0..DEPTH
//   peak_level    out  AW+1     max occupancy since reset/clear (FIFO_PEAK_EN)
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): wptr=rptr=0, count=0, data_out=0, rd_valid=0,
//     overflow=underflow=0, peak_level=0; empty=1, full=0, almost_empty=1 (AE_LEVEL>=0),
//     almost_full=0. Memory contents not reset. Reset mid-operation discards all data.
//   - rd_acc = rd & ~fifo_empty.
//   - wr_acc = wr & (~fifo_full | rd_acc): write while full is accepted only with a
//     same-cycle accepted read (slot freed); count unchanged.
//   - Read on empty with same-cycle write: read rejected, write accepted, underflow set.
//   - wr_acc: mem[wptr[AW-1:0]] <= data_in; wptr <= wptr+1 (wraps mod 2*DEPTH).
//   - rd_acc: data_out <= mem[rptr[AW-1:0]]; rptr <= rptr+1; rd_valid=1 next cycle.
//     Latency 1 clk from accepted rd to data_out/rd_valid. data_out holds when no read.
//   - count <= count + wr_acc - rd_acc; flags combinational from registered count.
//   - full: pointer low bits equal, wrap bits differ; empty: pointers equal; must match count.
//   - fifo_overflow set on wr & ~wr_acc; fifo_underflow set on rd & ~rd_acc; both hold
//     until clr_flags or rst. Set has priority over clr_flags in the same cycle.
//   - No state machine; state = pointers, count, sticky flags, peak register.
// CONFIGURATION
//   FIFO_PEAK_EN defined: peak_level <= max(peak_level, next count) each cycle;
//     clr_flags loads peak_level with current count.
//   FIFO_PEAK_EN undefined: no peak register; peak_level tied to 0.
// TESTING (DATA_W=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=4)
//   1 rst; write 0x01..0x10 -> full=1 after 16th, count=16, almost_full from count 12,
//     then read 16 -> data_out 0x01..0x10 in order, each 1 clk after rd, empty=1.
//   2 full, wr=1 data 0xAA, rd=0 -> overflow=1, count=16; clr_flags -> overflow=0.
//   3 empty, rd=1 & wr=1 data 0x55 -> underflow=1, count=1, next read returns 0x55.
//   4 full, wr=1 & rd=1 for 40 cycles, incrementing data -> count stays 16, no overflow,
//     order preserved across pointer wrap.
//   5 mid-stream (count=7) assert rst -> next cycle count=0, empty=1, rd_valid=0, flags=0.
//   6 FIFO_PEAK_EN: fill to 9, drain to 2 -> peak_level=9; clr_flags -> peak_level=2.

Source files
------------

// File: rtl/iiitb_fifo_param_if.sv
// Handshake/status bundle for iiitb_fifo_param.
// master = producer/consumer side, slave = the FIFO itself.
interface iiitb_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic              clr_flags;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              fifo_full;
    logic              fifo_empty;
    logic              almost_full;
    logic              almost_empty;
    logic              fifo_overflow;
    logic              fifo_underflow;
    logic [AW:0]       count;
    logic [AW:0]       peak_level;

    modport master (
        output wr, data_in, rd, clr_flags,
        input  data_out, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
               fifo_overflow, fifo_underflow, count, peak_level
    );

    modport slave (
        input  wr, data_in, rd, clr_flags,
        output data_out, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
               fifo_overflow, fifo_underflow, count, peak_level
    );
endinterface

// File: rtl/iiitb_fifo_param.sv
// Parametrised synchronous FIFO: registered read port, occupancy count, almost flags,
// sticky overflow/underflow. Define FIFO_PEAK_EN to add the peak occupancy register.
module iiitb_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic               clk,
    input  logic               rst,
    iiitb_fifo_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rvld_q, rvld_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              empty, full, rd_acc, wr_acc;

    // Wrap bit distinguishes full from empty when the low pointer bits match.
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign rd_acc = bus.rd & ~empty;
    assign wr_acc = bus.wr & (~full | rd_acc);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        dout_d  = dout_q;
        rvld_d  = 1'b0;
        count_d = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (wr_acc) wptr_d = wptr_q + ONE;
        if (rd_acc) begin
            rptr_d = rptr_q + ONE;
            dout_d = mem_q[rptr_q[AW-1:0]];
            rvld_d = 1'b1;
        end
        // A new rejection wins over a same-cycle clear.
        if (bus.wr & ~wr_acc)  ovf_d = 1'b1;
        else if (bus.clr_flags) ovf_d = 1'b0;
        if (bus.rd & ~rd_acc)  udf_d = 1'b1;
        else if (bus.clr_flags) udf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            rvld_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            rvld_q  <= rvld_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q[AW-1:0]] <= bus.data_in;
    end

`ifdef FIFO_PEAK_EN
    logic [AW:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (bus.clr_flags)        peak_d = count_q;
        else if (count_d > peak_q) peak_d = count_d;
    end

    always_ff @(posedge clk) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end

    assign bus.peak_level = peak_q;
`else
    assign bus.peak_level = '0;
`endif

    assign bus.data_out       = dout_q;
    assign bus.rd_valid       = rvld_q;
    assign bus.count          = count_q;
    assign bus.fifo_empty     = empty;
    assign bus.fifo_full      = full;
    assign bus.almost_full    = (count_q >= AF_L);
    assign bus.almost_empty   = (count_q <= AE_L);
    assign bus.fifo_overflow  = ovf_q;
    assign bus.fifo_underflow = udf_q;
endmodule

// File: tb/tb_iiitb_fifo_param.sv
// Randomised + directed bench for iiitb_fifo_param against a queue-based model.
// Peak checks follow FIFO_PEAK_EN the same way the design does.
module tb_iiitb_fifo_param;
    localparam int DW = 8, DP = 16, AF = 12, AE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    iiitb_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) bus ();
    iiitb_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    bit            m_vld, m_ovf, m_udf;
    int            m_peak;
    int            n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("count",  32'(bus.count), q.size());
        chk("empty",  32'(bus.fifo_empty), q.size() == 0);
        chk("full",   32'(bus.fifo_full), q.size() == DP);
        chk("afull",  32'(bus.almost_full), q.size() >= AF);
        chk("aempty", 32'(bus.almost_empty), q.size() <= AE);
        chk("ovf",    32'(bus.fifo_overflow), m_ovf);
        chk("udf",    32'(bus.fifo_underflow), m_udf);
        chk("rvld",   32'(bus.rd_valid), m_vld);
        chk("dout",   32'(bus.data_out), m_dout);
`ifdef FIFO_PEAK_EN
        chk("peak",   32'(bus.peak_level), m_peak);
`else
        chk("peak",   32'(bus.peak_level), 0);
`endif
    endtask

    // Called just after a falling edge: drive, advance the model, clock, check.
    task automatic cycle(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        bit e, f, racc, wacc;
        int old_n;
        bus.wr = w; bus.rd = r; bus.clr_flags = c; bus.data_in = d;
        old_n = q.size();
        e    = (old_n == 0);
        f    = (old_n == DP);
        racc = r && !e;
        wacc = w && (!f || racc);
        m_vld = racc;
        if (racc) m_dout = q.pop_front();
        if (wacc) q.push_back(d);
        if (w && !wacc) m_ovf = 1; else if (c) m_ovf = 0;
        if (r && !racc) m_udf = 1; else if (c) m_udf = 0;
        if (c) m_peak = old_n; else if (q.size() > m_peak) m_peak = q.size();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr = 0; bus.rd = 0; bus.clr_flags = 0; bus.data_in = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_dout = '0; m_vld = 0; m_ovf = 0; m_udf = 0; m_peak = 0;
        check_all();
    endtask

    initial begin
        int pw, pr;
        bus.wr = 0; bus.rd = 0; bus.clr_flags = 0; bus.data_in = '0;
        @(negedge clk);
        do_reset();

        // 1: fill 0x01..0x10, then drain in order
        for (int i = 1; i <= DP; i++) cycle(1, 0, 0, DW'(i));
        for (int i = 1; i <= DP; i++) begin
            cycle(0, 1, 0, '0);
            chk("order", 32'(bus.data_out), i);
        end
        cycle(0, 0, 0, '0);

        // 2: overflow on full, then clear
        for (int i = 0; i < DP; i++) cycle(1, 0, 0, 8'(32'h20 + i));
        cycle(1, 0, 0, 8'hAA);
        cycle(0, 0, 1, '0);

        // 4: full with simultaneous read/write across pointer wrap
        for (int i = 0; i < 40; i++) cycle(1, 1, 0, 8'(32'h80 + i));
        for (int i = 0; i < DP; i++) cycle(0, 1, 0, '0);

        // 3: read+write on empty -> underflow, write accepted
        cycle(1, 1, 0, 8'h55);
        cycle(0, 1, 0, '0);
        chk("uf_data", 32'(bus.data_out), 32'h55);
        cycle(0, 0, 1, '0);

        // 6: fill to 9, drain to 2, clear loads peak with current count
        for (int i = 0; i < 9; i++) cycle(1, 0, 0, DW'($urandom));
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, '0);
        cycle(0, 0, 1, '0);

        // 5: reset mid-stream at count 7
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, DW'($urandom));
        chk("pre_rst", 32'(bus.count), 7);
        cycle(1, 1, 0, 8'h11);
        do_reset();

        // Random phases with varying write/read bias
        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 3 == 0) ? 75 : (ph % 3 == 1) ? 25 : 50;
            pr = 100 - pw;
            for (int i = 0; i < 400; i++)
                cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                      $urandom_range(0, 99) < 5, DW'($urandom));
            if (ph == 3) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
